// File: rtl/link_pkg.sv
// Shared types and defaults for the link block reader.
package link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        CMD,
        DATA,
        FINISH
    } link_state_t;

    localparam logic [7:0] CMD_READ_DEFAULT = 8'hA5;

endpackage

// File: rtl/link_block_reader_sck_gen.sv
// Serial clock divider: low phase first, SCK_DIV clk cycles per half-period,
// plus one-cycle enables flagging the last cycle before each sck edge.
module sck_gen #(
    parameter int SCK_DIV = 4
) (
    input  logic clk,
    input  logic arstn,
    input  logic en,
    output logic sck,
    output logic fall_pre,
    output logic rise_pre
);

    localparam logic [7:0] LAST = 8'(SCK_DIV - 1);

    logic [7:0] cnt;
    logic       phase_end;

    // Dropping en parks sck low and rewinds the phase so the next run starts low.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign phase_end = en && (cnt == LAST);
    assign rise_pre  = phase_end && !sck;
    assign fall_pre  = phase_end && sck;

endmodule

// File: rtl/link_block_reader.sv
// Reads one block from a remote device: waits for rdy, sends a command byte,
// then clocks in BLOCKSIZE bytes MSB first.
module link_block_reader
    import link_pkg::*;
#(
    parameter int          BLOCKSIZE = 8192,
    parameter int          SCK_DIV   = 4,
    parameter logic [7:0]  CMD_READ  = CMD_READ_DEFAULT
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       start,
    input  logic       rdy,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       busy,
    output logic       done
);

    localparam int              BCW       = $clog2(BLOCKSIZE + 1);
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BLOCKSIZE - 1);

    link_state_t    state;
    logic [1:0]     rdy_sync;
    logic [1:0]     miso_sync;
    logic           rdy_s;
    logic           miso_s;
    logic [2:0]     bit_cnt;
    logic [BCW-1:0] byte_cnt;
    logic [7:0]     cmd_sr;
    logic [6:0]     shift_sr;
    logic           sck_en;
    logic           fall_pre;
    logic           rise_pre;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rdy_sync  <= '0;
            miso_sync <= '0;
        end else begin
            rdy_sync  <= {rdy_sync[0], rdy};
            miso_sync <= {miso_sync[0], miso};
        end
    end

    assign rdy_s  = rdy_sync[1];
    assign miso_s = miso_sync[1];
    assign sck_en = (state == CMD) || (state == DATA);

    sck_gen #(
        .SCK_DIV (SCK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .arstn    (arstn),
        .en       (sck_en),
        .sck      (sck),
        .fall_pre (fall_pre),
        .rise_pre (rise_pre)
    );

    // bit_cnt advances as each sck period goes high, so it reads 0 at the
    // falling edge that closes the 8th period of a byte.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            cmd_sr     <= '0;
            shift_sr   <= '0;
            mosi       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            done       <= 1'b0;
            if (rise_pre) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WAIT_RDY;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end
                WAIT_RDY: begin
                    if (rdy_s) begin
                        state  <= CMD;
                        mosi   <= CMD_READ[7];
                        cmd_sr <= {CMD_READ[6:0], 1'b0};
                    end
                end
                CMD: begin
                    // mosi moves with the falling edge, so it is stable across every high phase.
                    if (fall_pre) begin
                        if (bit_cnt == 3'd0) begin
                            state <= DATA;
                            mosi  <= 1'b0;
                        end else begin
                            mosi   <= cmd_sr[7];
                            cmd_sr <= {cmd_sr[6:0], 1'b0};
                        end
                    end
                end
                DATA: begin
                    if (fall_pre) begin
                        shift_sr <= {shift_sr[5:0], miso_s};
                        if (bit_cnt == 3'd0) begin
                            dout       <= {shift_sr, miso_s};
                            dout_valid <= 1'b1;
                            byte_cnt   <= byte_cnt + BCW'(1);
                            if (byte_cnt == LAST_BYTE) begin
                                state <= FINISH;
                            end
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_link_block_reader.sv
// Directed bench for link_block_reader with a responder model per DUT and a
// byte scoreboard filled when each block is requested.
module tb_link_block_reader;

    localparam int BS = 4;

    logic clk = 1'b0;
    logic arstn = 1'b0;

    logic       start4 = 1'b0, rdy4 = 1'b0, miso4;
    logic       sck4, mosi4, dout_valid4, busy4, done4;
    logic [7:0] dout4;
    logic       start3 = 1'b0, rdy3 = 1'b1, miso3;
    logic       sck3, mosi3, dout_valid3, busy3, done3;
    logic [7:0] dout3;

    always #5 clk = ~clk;

    link_block_reader #(.BLOCKSIZE(BS), .SCK_DIV(4), .CMD_READ(8'hA5)) dut4 (
        .clk(clk), .arstn(arstn), .start(start4), .rdy(rdy4), .miso(miso4),
        .sck(sck4), .mosi(mosi4), .dout(dout4), .dout_valid(dout_valid4),
        .busy(busy4), .done(done4)
    );

    link_block_reader #(.BLOCKSIZE(BS), .SCK_DIV(3), .CMD_READ(8'hA5)) dut3 (
        .clk(clk), .arstn(arstn), .start(start3), .rdy(rdy3), .miso(miso3),
        .sck(sck3), .mosi(mosi3), .dout(dout3), .dout_valid(dout_valid3),
        .busy(busy3), .done(done3)
    );

    int n_compared = 0;
    int n_mismatched = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and strobe monitor, sampled on the falling clk edge.
    logic [7:0] q4[$];
    logic [7:0] q3[$];
    logic [7:0] e4, e3;
    int rx4 = 0, rx3 = 0, done_cnt4 = 0, done_cnt3 = 0;

    always @(negedge clk) begin
        if (dout_valid4) begin
            e4 = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
            check_output("dout4", {24'd0, dout4}, {24'd0, e4});
            rx4++;
        end
        if (done4) begin
            done_cnt4++;
            check_output("busy_at_done4", {31'd0, busy4}, 32'd0);
        end
        if (dout_valid3) begin
            e3 = (q3.size() > 0) ? q3.pop_front() : 8'hxx;
            check_output("dout3", {24'd0, dout3}, {24'd0, e3});
            rx3++;
        end
        if (done3) begin
            done_cnt3++;
        end
    end

    // Responder for dut4: updates miso on sck fall, logs the command bits.
    logic [7:0] data4 [BS];
    logic [7:0] cmd_rx4;
    int r4 = 0, f4 = 0, mosi_err4 = 0;
    logic resp_clr4 = 1'b0;

    always @(posedge sck4 or negedge sck4 or posedge resp_clr4) begin
        if (resp_clr4) begin
            r4 <= 0;
            f4 <= 0;
            mosi_err4 <= 0;
            cmd_rx4 <= 8'd0;
            miso4 <= 1'b0;
        end else if (sck4) begin
            if (r4 < 8) cmd_rx4 <= {cmd_rx4[6:0], mosi4};
            else if (mosi4 !== 1'b0) mosi_err4 <= mosi_err4 + 1;
            r4 <= r4 + 1;
        end else begin
            miso4 <= (f4 >= 7 && f4 < 7 + 8*BS) ? data4[(f4-7)/8][7-((f4-7)%8)] : 1'b0;
            f4 <= f4 + 1;
        end
    end

    // Responder for dut3: updates miso on sck rise.
    logic [7:0] data3 [BS];
    logic [7:0] cmd_rx3;
    int r3 = 0;
    logic resp_clr3 = 1'b0;

    always @(posedge sck3 or posedge resp_clr3) begin
        if (resp_clr3) begin
            r3 <= 0;
            cmd_rx3 <= 8'd0;
            miso3 <= 1'b0;
        end else begin
            if (r3 < 8) cmd_rx3 <= {cmd_rx3[6:0], mosi3};
            miso3 <= (r3 >= 8 && r3 < 8 + 8*BS) ? data3[(r3-8)/8][7-((r3-8)%8)] : 1'b0;
            r3 <= r3 + 1;
        end
    end

    task automatic apply_stimulus4(input logic [7:0] b [BS]);
        data4 = b;
        for (int i = 0; i < BS; i++) q4.push_back(b[i]);
        resp_clr4 = 1'b1;
        #1 resp_clr4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic apply_stimulus3(input logic [7:0] b [BS]);
        data3 = b;
        for (int i = 0; i < BS; i++) q3.push_back(b[i]);
        resp_clr3 = 1'b1;
        #1 resp_clr3 = 1'b0;
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
    endtask

    task automatic wait_done4(input int budget);
        int k = 0;
        while (!done4 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_output("done4_seen", {31'd0, done4}, 32'd1);
        @(negedge clk);
    endtask

    int base_rx, base_done, k, sck_hi;

    initial begin
        resp_clr4 = 1'b1;
        resp_clr3 = 1'b1;
        repeat (3) @(negedge clk);
        resp_clr4 = 1'b0;
        resp_clr3 = 1'b0;
        check_output("rst_sck", {31'd0, sck4}, 32'd0);
        check_output("rst_mosi", {31'd0, mosi4}, 32'd0);
        check_output("rst_dout", {24'd0, dout4}, 32'd0);
        check_output("rst_dout_valid", {31'd0, dout_valid4}, 32'd0);
        check_output("rst_busy", {31'd0, busy4}, 32'd0);
        check_output("rst_done", {31'd0, done4}, 32'd0);
        arstn = 1'b1;
        repeat (2) @(negedge clk);

        // Basic block with rdy already high.
        $display("[TB] basic block");
        rdy4 = 1'b1;
        base_rx = rx4; base_done = done_cnt4;
        apply_stimulus4('{8'h01, 8'h80, 8'hFF, 8'h3C});
        check_output("busy_after_start", {31'd0, busy4}, 32'd1);
        wait_done4(2000);
        check_output("cmd_byte", {24'd0, cmd_rx4}, 32'hA5);
        check_output("sck_rises", r4, 8 + 8*BS);
        check_output("mosi_in_data", mosi_err4, 0);
        check_output("bytes_basic", rx4 - base_rx, BS);
        check_output("dones_basic", done_cnt4 - base_done, 1);
        check_output("queue_basic", q4.size(), 0);
        check_output("busy_after_done", {31'd0, busy4}, 32'd0);
        check_output("sck_idle", {31'd0, sck4}, 32'd0);
        repeat (10) @(negedge clk);
        check_output("dout_hold", {24'd0, dout4}, 32'h3C);

        // Start while rdy is low: no sck until rdy rises.
        $display("[TB] rdy held low");
        rdy4 = 1'b0;
        base_rx = rx4;
        apply_stimulus4('{8'hDE, 8'hAD, 8'hBE, 8'hEF});
        sck_hi = 0;
        repeat (500) begin
            @(negedge clk);
            if (sck4) sck_hi++;
        end
        check_output("sck_while_not_rdy", sck_hi, 0);
        check_output("busy_while_wait", {31'd0, busy4}, 32'd1);
        rdy4 = 1'b1;
        k = 0;
        while (!mosi4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_output("rdy_to_cmd_latency_ok", {31'd0, (k >= 1 && k <= 4)}, 32'd1);
        wait_done4(2000);
        check_output("bytes_rdy_wait", rx4 - base_rx, BS);

        // Extra start pulses mid-block are ignored.
        $display("[TB] extra starts");
        base_rx = rx4; base_done = done_cnt4;
        apply_stimulus4('{8'h11, 8'h22, 8'h33, 8'h44});
        repeat (2) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (46) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(2000);
        repeat (400) @(negedge clk);
        check_output("dones_extra_start", done_cnt4 - base_done, 1);
        check_output("bytes_extra_start", rx4 - base_rx, BS);
        check_output("idle_extra_start", {31'd0, busy4}, 32'd0);

        // Reset after the second byte aborts without done.
        $display("[TB] reset mid-block");
        base_rx = rx4; base_done = done_cnt4;
        apply_stimulus4('{8'hA1, 8'hB2, 8'hC3, 8'hD4});
        k = 0;
        while (rx4 - base_rx < 2 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_output("two_bytes_before_reset", rx4 - base_rx, 2);
        arstn = 1'b0;
        #1;
        check_output("abort_sck", {31'd0, sck4}, 32'd0);
        check_output("abort_mosi", {31'd0, mosi4}, 32'd0);
        check_output("abort_dout", {24'd0, dout4}, 32'd0);
        check_output("abort_busy", {31'd0, busy4}, 32'd0);
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        q4.delete();
        repeat (400) @(negedge clk);
        check_output("no_done_after_abort", done_cnt4 - base_done, 0);
        check_output("no_restart_after_abort", {31'd0, busy4}, 32'd0);
        base_rx = rx4;
        apply_stimulus4('{8'h5A, 8'hC6, 8'h0F, 8'h81});
        wait_done4(2000);
        check_output("bytes_after_abort", rx4 - base_rx, BS);

        // rdy falling during DATA does not stop the block.
        $display("[TB] rdy drop mid-data");
        base_rx = rx4; base_done = done_cnt4;
        apply_stimulus4('{8'h7E, 8'hE7, 8'h42, 8'h24});
        k = 0;
        while (rx4 - base_rx < 1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        rdy4 = 1'b0;
        wait_done4(2000);
        check_output("bytes_rdy_drop", rx4 - base_rx, BS);
        check_output("dones_rdy_drop", done_cnt4 - base_done, 1);
        rdy4 = 1'b1;

        // Minimum divider with miso changing on sck rise.
        $display("[TB] SCK_DIV=3 block");
        apply_stimulus3('{8'hAA, 8'h55, 8'h00, 8'hFF});
        k = 0;
        while (!done3 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_output("done3_seen", {31'd0, done3}, 32'd1);
        @(negedge clk);
        check_output("cmd_byte3", {24'd0, cmd_rx3}, 32'hA5);
        check_output("bytes3", rx3, BS);
        check_output("dones3", done_cnt3, 1);
        check_output("queue3", q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
